// File: rtl/zone_fish_counter.sv
// ---------------------------------------------------------------------------
// zone_fish_counter
//
// Counts fish passing through a drawn "green zone" of a video stream. Every
// pixel cycle where the pixel is valid, inside the zone and marked as
// foreground is a hit. Hits are accumulated per frame. At each frame_start
// the frame total is latched and classified as "on" (fish present) or "off"
// (zone clear). A hysteresis FSM turns runs of on/off frames into occupancy.
// Each completed occupancy (enter, then leave) counts as one fish passage.
//
// Optional feature, macro ZONE_FISH_PEAK_EN: adds occ_peak, the largest frame
// hit count seen during the current or most recent occupancy.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   en           active-video pixel valid
//   zone         registered in-zone flag, cycle-aligned with pix_fg
//   pix_fg       foreground mask bit of the current pixel
//   frame_start  one-cycle pulse on the first cycle of a frame
//   cnt_clr      synchronous clear of fish_count
//   fish_count   completed fish passages (wraps modulo 2^16)
//   occupied     zone currently holds a fish
//   count_pulse  one-cycle strobe on each fish_count increment
//   frame_pix    hit count of the last completed frame
//   occ_peak     (ZONE_FISH_PEAK_EN only) peak frame hit count of occupancy
// ---------------------------------------------------------------------------
module zone_fish_counter #(
  parameter logic [19:0] THR_ON  = 20'd400,
  parameter logic [19:0] THR_OFF = 20'd200,
  parameter logic [3:0]  N_ON    = 4'd3,
  parameter logic [3:0]  N_OFF   = 4'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        zone,
  input  logic        pix_fg,
  input  logic        frame_start,
  input  logic        cnt_clr,
  output logic [15:0] fish_count,
  output logic        occupied,
  output logic        count_pulse,
  output logic [19:0] frame_pix
`ifdef ZONE_FISH_PEAK_EN
  ,
  output logic [19:0] occ_peak
`endif
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    ARMING    = 2'd1,
    OCCUPIED  = 2'd2,
    RELEASING = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  run_r;
  logic [3:0]  run_nxt_s;
  logic [3:0]  run_inc_s;
  logic        inc_s;
  logic        hit_s;
  logic        on_s;
  logic        off_s;
  logic [19:0] acc_r;
  logic [19:0] frame_pix_r;
  logic [15:0] fish_count_r;
  logic        occupied_r;
  logic        count_pulse_r;

  assign hit_s     = en & zone & pix_fg;
  // Classification looks at the accumulator before this cycle's reload,
  // i.e. exactly the value being latched into frame_pix on this edge.
  assign on_s      = (acc_r >= THR_ON);
  assign off_s     = (acc_r < THR_OFF);
  assign run_inc_s = run_r + 4'd1;

  // Per-frame hit accumulator and frame total latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r       <= 20'd0;
      frame_pix_r <= 20'd0;
    end else if (frame_start) begin
      // The hit on the frame_start cycle belongs to the new frame.
      frame_pix_r <= acc_r;
      acc_r       <= {19'd0, hit_s};
    end else if (hit_s && (acc_r != 20'hFFFFF)) begin
      acc_r <= acc_r + 20'd1;
    end else begin
      acc_r <= acc_r;
    end
  end

  // Occupancy FSM next-state, run counter and passage-increment decode.
  always_comb begin
    state_nxt_s = state_r;
    run_nxt_s   = run_r;
    inc_s       = 1'b0;
    if (frame_start) begin
      case (state_r)
        EMPTY: begin
          if (on_s) begin
            if (N_ON == 4'd1) begin
              state_nxt_s = OCCUPIED;
              run_nxt_s   = 4'd0;
            end else begin
              state_nxt_s = ARMING;
              run_nxt_s   = 4'd1;
            end
          end else begin
            state_nxt_s = EMPTY;
            run_nxt_s   = 4'd0;
          end
        end
        ARMING: begin
          if (on_s) begin
            if (run_inc_s == N_ON) begin
              state_nxt_s = OCCUPIED;
              run_nxt_s   = 4'd0;
            end else begin
              run_nxt_s   = run_inc_s;
            end
          end else begin
            state_nxt_s = EMPTY;
            run_nxt_s   = 4'd0;
          end
        end
        OCCUPIED: begin
          if (off_s) begin
            if (N_OFF == 4'd1) begin
              state_nxt_s = EMPTY;
              run_nxt_s   = 4'd0;
              inc_s       = 1'b1;
            end else begin
              state_nxt_s = RELEASING;
              run_nxt_s   = 4'd1;
            end
          end else begin
            state_nxt_s = OCCUPIED;
            run_nxt_s   = 4'd0;
          end
        end
        RELEASING: begin
          if (off_s) begin
            if (run_inc_s == N_OFF) begin
              state_nxt_s = EMPTY;
              run_nxt_s   = 4'd0;
              inc_s       = 1'b1;
            end else begin
              run_nxt_s   = run_inc_s;
            end
          end else begin
            state_nxt_s = OCCUPIED;
            run_nxt_s   = 4'd0;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
          run_nxt_s   = 4'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      run_nxt_s   = run_r;
    end
  end

  // FSM state, run counter and registered occupied flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= EMPTY;
      run_r      <= 4'd0;
      occupied_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      run_r      <= run_nxt_s;
      occupied_r <= (state_nxt_s == OCCUPIED) || (state_nxt_s == RELEASING);
    end
  end

  // Passage counter and increment strobe; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      fish_count_r  <= 16'd0;
      count_pulse_r <= 1'b0;
    end else begin
      count_pulse_r <= inc_s;
      if (cnt_clr) begin
        fish_count_r <= 16'd0;
      end else if (inc_s) begin
        fish_count_r <= fish_count_r + 16'd1;
      end else begin
        fish_count_r <= fish_count_r;
      end
    end
  end

`ifdef ZONE_FISH_PEAK_EN
  logic [19:0] occ_peak_r;

  // Peak frame hit count: restarts on entry to occupancy, held while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_peak_r <= 20'd0;
    end else if (frame_start) begin
      if ((state_r == OCCUPIED) || (state_r == RELEASING)) begin
        occ_peak_r <= (acc_r > occ_peak_r) ? acc_r : occ_peak_r;
      end else if (state_nxt_s == OCCUPIED) begin
        occ_peak_r <= 20'd0;
      end else begin
        occ_peak_r <= occ_peak_r;
      end
    end else begin
      occ_peak_r <= occ_peak_r;
    end
  end

  assign occ_peak = occ_peak_r;
`else
  // Peak tracking not built: no occ_peak register or port.
`endif

  assign fish_count  = fish_count_r;
  assign occupied    = occupied_r;
  assign count_pulse = count_pulse_r;
  assign frame_pix   = frame_pix_r;

endmodule

// File: doc/zone_fish_counter.md
ZONE_FISH_COUNTER -- requirements
Module: zone_fish_counter

Interface
REQ-001 SHALL have parameter THR_ON, 20'd400, per-frame hit count at or above which a frame is "on".
REQ-002 SHALL have parameter THR_OFF, 20'd200, per-frame hit count below which a frame is "off"; THR_OFF <= THR_ON.
REQ-003 SHALL have parameter N_ON, 4'd3, consecutive "on" frames required to enter occupancy; legal 1..15.
REQ-004 SHALL have parameter N_OFF, 4'd5, consecutive "off" frames required to leave occupancy; legal 1..15.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port en, input, 1, active-video pixel valid.
REQ-008 SHALL have port zone, input, 1, registered in-zone flag from the green-zone draw stage, cycle-aligned with pix_fg.
REQ-009 SHALL have port pix_fg, input, 1, foreground (fish) mask bit for the current pixel.
REQ-010 SHALL have port frame_start, input, 1, one-cycle pulse marking the first cycle of a new frame.
REQ-011 SHALL have port cnt_clr, input, 1, synchronous clear of fish_count.
REQ-012 SHALL have port fish_count, output, 16, number of completed fish passages.
REQ-013 SHALL have port occupied, output, 1, zone currently holds a fish.
REQ-014 SHALL have port count_pulse, output, 1, one-cycle strobe on each fish_count increment.
REQ-015 SHALL have port frame_pix, output, 20, hit count of the last completed frame.

Function
REQ-016 SHALL define hit = en & zone & pix_fg; the accumulator SHALL add 1 per hit cycle, saturating at 20'hFFFFF.
REQ-017 SHALL, on a frame_start cycle, latch the accumulator (excluding that cycle's hit) into frame_pix and reload the accumulator with hit (1 or 0).
REQ-018 SHALL classify the latched value in the same edge: on = acc >= THR_ON, off = acc < THR_OFF, else neither.
REQ-019 SHALL implement FSM states EMPTY, ARMING, OCCUPIED, RELEASING with 4-bit run counter, evaluated only on frame_start.
REQ-020 EMPTY: on -> ARMING with run=1, or directly OCCUPIED if N_ON==1; otherwise stay.
REQ-021 ARMING: on -> run+1, OCCUPIED when run+1==N_ON; not on -> EMPTY, run=0.
REQ-022 OCCUPIED: off -> RELEASING with run=1, or directly EMPTY with increment if N_OFF==1; otherwise stay.
REQ-023 RELEASING: off -> run+1, EMPTY with increment when run+1==N_OFF; not off -> OCCUPIED, run=0.
REQ-024 occupied SHALL be 1 in OCCUPIED and RELEASING, registered, valid one cycle after the deciding frame_start.
REQ-025 An increment SHALL add 1 to fish_count modulo 2^16 (0xFFFF -> 0x0000) and assert count_pulse for exactly the following cycle.
REQ-026 cnt_clr SHALL set fish_count to 0 next cycle; simultaneous with an increment, clear wins (result 0) while count_pulse still asserts.
REQ-027 Frames without frame_start SHALL keep accumulating (saturating); no FSM evaluation occurs.

Reset
REQ-028 reset SHALL force state EMPTY, run 0, accumulator 0, fish_count 0, frame_pix 0, occupied 0, count_pulse 0 (and occ_peak 0 if present); reset wins over all inputs including frame_start.
REQ-029 reset mid-frame SHALL discard the partial accumulation; the first frame_start after reset latches only hits since reset release.

Configuration
REQ-030 With macro ZONE_FISH_PEAK_EN defined, SHALL add output occ_peak[19:0]: cleared on entry to OCCUPIED, updated to max(occ_peak, latched value) on each frame_start while in OCCUPIED/RELEASING, held in EMPTY/ARMING.
REQ-031 Without ZONE_FISH_PEAK_EN, occ_peak port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Frame of 500 hits then frame_start -> frame_pix=500 next cycle; hit on frame_start cycle counts as 1 in next frame.
REQ-033 Defaults; frames 500,500,500 then 100x5 -> occupied rises after 3rd frame_start, falls after 5th low frame with fish_count=1, count_pulse 1 cycle.
REQ-034 Frames 500,500,300,500 -> ARMING aborted at 300 (not on), occupied stays 0, fish_count=0.
REQ-035 Preload fish_count to 0xFFFF via 65535 passages (or force), one more passage -> 0x0000 with count_pulse; cnt_clr on same cycle -> 0.
REQ-036 2^20+10 hits in one frame -> frame_pix=0xFFFFF; reset asserted mid-frame -> all outputs 0, next frame_start latches only post-reset hits.
REQ-037 ZONE_FISH_PEAK_EN: occupancy frames 450,700,600 -> occ_peak=700; held after return to EMPTY.
